if_id_fetch_queue: RTL and testbench
====================================

Name: if_id_fetch_queue

Overview:
- Parametrised successor of the single-entry IF→ID pipeline register: a DEPTH-entry in-order instruction queue between fetch and decode.
- Absorbs decode stalls (e.g. a DCache stall) without back-pressuring fetch until the queue is full.
- Any of N_FLUSH flush sources (EX branch, ICache, predecoder branch, ...) empties the queue in one cycle.
- Uses a valid/ready handshake on both sides instead of a bare stall input; an empty queue presents an all-zero bubble.

Parameters:
WIDTH, 32, bit width of PC and instruction fields
DEPTH, 4, number of queue entries; power of two, ≥2
N_FLUSH, 3, number of independent flush request inputs
CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived; do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  N_FLUSH  flush requests; any bit high = flush this cycle
in_valid  in  1  fetch presents a valid PC/inst pair
in_ready  out  1  queue can accept an entry this cycle
in_pc  in  WIDTH  fetched PC
in_inst  in  WIDTH  fetched instruction word
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode accepts head (low = decode stall)
out_pc  out  WIDTH  head PC, 0 when out_valid=0
out_inst  out  WIDTH  head instruction, 0 when out_valid=0
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH×(2·WIDTH) array; rd_ptr and wr_ptr of $clog2(DEPTH) bits wrap naturally modulo DEPTH; count register holds occupancy.
- Reset (rst_n low, asynchronous): count=0, rd_ptr=wr_ptr=0, so out_valid=0, out_pc=0, out_inst=0, in_ready=1. Array contents need not be reset. Reset asserted mid-operation discards all entries immediately, independent of clk.
- in_ready = (count != DEPTH). Depends on registered state only; no combinational path from out_ready or flush.
- out_valid = (count != 0). out_pc/out_inst = head entry when out_valid, else forced to 0. These are combinational from registered state only.
- flush_any = |flush.
- push = in_valid & in_ready & ~flush_any: write array[wr_ptr], then wr_ptr+1.
- pop = out_valid & out_ready & ~flush_any: rd_ptr+1.
- count next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- Flush: on the edge after flush_any=1, count=0 and rd_ptr=wr_ptr=0. Any push or pop in that cycle is discarded. Flush has priority over stall (out_ready=0); this is a deliberate change from the single-entry register, where stall overrode flush.
- Latency: minimum 1 cycle from an accepted push to out_valid. There is no combinational bypass when empty. A push into an empty queue appears at the output on the next cycle.
- Full: in_ready=0. A simultaneous pop does not enable a push that cycle, so there is no full pass-through. Throughput is 1/cycle whenever 0<count<DEPTH.
- Empty: out_valid=0; out_ready is ignored.
- Order: strictly FIFO; entries are never reordered or duplicated.
- in_valid while in_ready=0: no effect. Fetch must hold its data until it sees in_ready=1.
- Assertions for verification: count≤DEPTH; (wr_ptr − rd_ptr) mod DEPTH == count mod DEPTH.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high → out_valid=0, out_pc=0, out_inst=0, in_ready=1, count=0.
- Streaming: push PC 0x1c000000..0x1c00001c (inst = PC^0xFFFF) with out_ready=1 every cycle → each pair appears at the output exactly 1 cycle after its push, in order; count stays at 1.
- Fill under stall: out_ready=0, push 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c → count=4, in_ready=0. A 5th in_valid is not accepted. Raising out_ready then drains the entries in order; the full-cycle pop does not admit a push that same cycle.
- Flush priority: count=3 with out_ready=0, assert flush[0] together with in_valid → next cycle count=0, out_valid=0, out_pc=0. The pushed entry is lost. Repeat with flush[2] and with flush=3'b111 and expect identical results.
- Wrap-around: with DEPTH=4, run 10 interleaved push/pop cycles that hold count at 2 → pointers wrap twice and output order matches input order exactly.
- Async reset mid-operation: count=3, pull rst_n low between clock edges → out_valid drops and count=0 before the next edge. After release, the first push appears at the output after 1 cycle.

Source files
------------

// File: rtl/if_id_fetch_queue.sv
// DEPTH-entry in-order instruction queue between fetch and decode.
// Valid/ready handshake on both sides; any flush source empties the queue in one cycle.
module if_id_fetch_queue #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int N_FLUSH = 3,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_FLUSH-1:0] flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_pc,
  input  logic [WIDTH-1:0]   in_inst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_pc,
  output logic [WIDTH-1:0]   out_inst,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             flush_any;
  logic             push;
  logic             pop;

  // Handshake outputs depend on registered state only; flush and out_ready
  // gate the internal push/pop, never in_ready/out_valid.
  always_comb begin
    flush_any = |flush;
    in_ready  = (count != FULL_CNT);
    out_valid = (count != '0);
    push      = in_valid & in_ready & ~flush_any;
    pop       = out_valid & out_ready & ~flush_any;
    out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;
    out_inst  = out_valid ? inst_mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush_any) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_CNT);
  a_ptr_count : assert property (@(posedge clk) disable iff (!rst_n)
    PTR_W'(wr_ptr - rd_ptr) == count[PTR_W-1:0]);

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_if_id_fetch_queue;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int N_FLUSH = 3;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N_FLUSH-1:0] flush;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_pc;
  logic [WIDTH-1:0]   in_inst;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_pc;
  logic [WIDTH-1:0]   out_inst;
  logic [CNT_W-1:0]   count;

  int tests = 0;
  int fails = 0;

  // Reference model: each element is {pc, inst}, head at index 0.
  logic [2*WIDTH-1:0] mq[$];

  if_id_fetch_queue #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .N_FLUSH(N_FLUSH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_inst(in_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] einst;
    epc   = '0;
    einst = '0;
    if (mq.size() > 0) begin
      epc   = mq[0][2*WIDTH-1:WIDTH];
      einst = mq[0][WIDTH-1:0];
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < DEPTH));
    chk({tag, ".count"},     64'(count),     64'(mq.size()));
    chk({tag, ".out_pc"},    64'(out_pc),    64'(epc));
    chk({tag, ".out_inst"},  64'(out_inst),  64'(einst));
  endtask

  // Drive one cycle of inputs (called #1 after a rising edge), advance the
  // model by the handshake rules, then check just after the next edge.
  task automatic cyc(input string tag, input logic iv, input logic [WIDTH-1:0] pc,
                     input logic [WIDTH-1:0] inst, input logic ordy,
                     input logic [N_FLUSH-1:0] fl);
    bit do_push;
    bit do_pop;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    do_push = iv && (mq.size() < DEPTH) && (fl == '0);
    do_pop  = ordy && (mq.size() > 0) && (fl == '0);
    @(posedge clk);
    #1;
    if (fl != '0) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back({pc, inst});
    end
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] pc;
    logic [N_FLUSH-1:0] fl_vals [3];
    fl_vals[0] = 3'b001;
    fl_vals[1] = 3'b100;
    fl_vals[2] = 3'b111;

    rst_n = 1'b0; flush = '0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset");
    cyc("idle", 1'b0, '0, '0, 1'b1, '0);

    // Streaming: each push surfaces one cycle later, count holds at 1
    for (int unsigned i = 0; i < 8; i++) begin
      pc = 32'h1c00_0000 + 32'(4 * i);
      cyc("stream", 1'b1, pc, pc ^ 32'h0000_FFFF, 1'b1, '0);
    end
    cyc("stream_tail", 1'b0, '0, '0, 1'b1, '0);

    // Fill under stall, a rejected 5th push, full-cycle pop with push, drain
    for (int unsigned i = 0; i < 4; i++) begin
      pc = 32'h1c00_0000 + 32'(4 * i);
      cyc("fill", 1'b1, pc, pc ^ 32'h0000_FFFF, 1'b0, '0);
    end
    cyc("full_reject", 1'b1, 32'h1c00_0010, 32'h1c00_ffef, 1'b0, '0);
    cyc("full_pop_push", 1'b1, 32'h1c00_0010, 32'h1c00_ffef, 1'b1, '0);
    repeat (4) cyc("drain", 1'b0, '0, '0, 1'b1, '0);

    // Flush beats stall and discards the same-cycle push
    foreach (fl_vals[k]) begin
      for (int unsigned i = 0; i < 3; i++) begin
        pc = 32'h2000_0000 + 32'(4 * i) + 32'(k << 8);
        cyc("flush_fill", 1'b1, pc, ~pc, 1'b0, '0);
      end
      cyc("flush", 1'b1, 32'hdead_beef, 32'hcafe_f00d, 1'b0, fl_vals[k]);
      cyc("flush_after", 1'b0, '0, '0, 1'b0, '0);
    end

    // Wrap-around at steady occupancy 2
    cyc("wrap_pre", 1'b1, 32'h3000_0000, 32'h1, 1'b0, '0);
    cyc("wrap_pre", 1'b1, 32'h3000_0004, 32'h2, 1'b0, '0);
    for (int unsigned i = 0; i < 10; i++)
      cyc("wrap", 1'b1, 32'h3000_0008 + 32'(4 * i), 32'(i + 3), 1'b1, '0);
    repeat (3) cyc("wrap_drain", 1'b0, '0, '0, 1'b1, '0);

    // Asynchronous reset between edges
    for (int unsigned i = 0; i < 3; i++)
      cyc("areset_fill", 1'b1, 32'h4000_0000 + 32'(4 * i), 32'(i), 1'b0, '0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    check_all("areset_mid");
    @(posedge clk);
    #1;
    check_all("areset_hold");
    rst_n = 1'b1;
    cyc("post_reset_push", 1'b1, 32'h5000_0000, 32'h5555_aaaa, 1'b0, '0);
    cyc("post_reset_pop", 1'b0, '0, '0, 1'b1, '0);

    // Random traffic with occasional flushes
    for (int unsigned i = 0; i < 400; i++) begin
      logic [N_FLUSH-1:0] fl;
      fl = ($urandom_range(0, 15) == 0) ? N_FLUSH'($urandom_range(1, (1 << N_FLUSH) - 1)) : '0;
      cyc("random", 1'($urandom_range(0, 1)), $urandom, $urandom,
          1'($urandom_range(0, 3) != 0), fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
